serial_subtractor: RTL and testbench

- Bit-serial unsigned subtractor, D = X - Y, one bit per clock, LSB first, with borrow-out.
- Sequential inverse-operation companion to the combinational 2-bit adder. Its result can be fed back through the adder for round-trip checks (Y + D == X modulo 2^WIDTH).
- Uses a start/busy/done handshake for use by lab-level control FSMs.

---
 rtl/serial_subtractor.sv | 122 ++++++++++++
 tb/tb_serial_subtractor.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor D = X - Y, LSB first, with final borrow-out.
// Latency: start accepted at edge N, done pulses in the cycle after edge N+WIDTH.
// Backpressure: none; start is ignored while busy, accepted in IDLE or on the DONE cycle.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             borrow
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] xs_q, xs_d;
  logic [WIDTH-1:0] ys_q, ys_d;
  logic [WIDTH-1:0] rs_q, rs_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             borrow_q, borrow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic a, b, diff, bnext, last, accept;

  // Next-state: one full-subtractor bit per SHIFT cycle; result published only on the last bit.
  always_comb begin
    a        = xs_q[0];
    b        = ys_q[0];
    diff     = a ^ b ^ c_q;
    bnext    = (~a & b) | (~(a ^ b) & c_q);
    last     = (cnt_q == CW'(WIDTH - 1));
    accept   = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    state_d  = state_q;
    xs_d     = xs_q;
    ys_d     = ys_q;
    rs_d     = rs_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    d_d      = d_q;
    borrow_d = borrow_q;

    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        xs_d  = {1'b0, xs_q[WIDTH-1:1]};
        ys_d  = {1'b0, ys_q[WIDTH-1:1]};
        rs_d  = {diff, rs_q[WIDTH-1:1]};
        c_d   = bnext;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          state_d  = S_DONE;
          d_d      = {diff, rs_q[WIDTH-1:1]};
          borrow_d = bnext;
        end
      end
      S_DONE: begin
        state_d = accept ? S_SHIFT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Operand capture shares one path for the IDLE and back-to-back DONE cases.
    if (accept) begin
      xs_d  = x;
      ys_d  = y;
      rs_d  = '0;
      c_d   = 1'b0;
      cnt_d = '0;
    end

    busy_d = (state_d == S_SHIFT);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      xs_q     <= '0;
      ys_q     <= '0;
      rs_q     <= '0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      d_q      <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      xs_q     <= xs_d;
      ys_q     <= ys_d;
      rs_q     <= rs_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      d_q      <= d_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign d      = d_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: WIDTH=2 and WIDTH=4 instances against an arithmetic model.
// Inputs driven and outputs sampled on the falling clock edge.
// Every wait on done is bounded; an expired bound is reported as a failure.
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start2, busy2, done2, borrow2;
  logic [1:0] x2, y2, d2;
  logic       start4, busy4, done4, borrow4;
  logic [3:0] x4, y4, d4;

  int n_cmp;
  int n_err;

  serial_subtractor #(.WIDTH(2)) u_w2 (
    .clk(clk), .rst(rst), .start(start2), .x(x2), .y(y2),
    .busy(busy2), .done(done2), .d(d2), .borrow(borrow2)
  );

  serial_subtractor #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .start(start4), .x(x4), .y(y4),
    .busy(busy4), .done(done4), .d(d4), .borrow(borrow4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One WIDTH=2 operation; lat = rising edges from the start edge to the edge raising done.
  task automatic op2(input logic [1:0] xa, input logic [1:0] ya,
                     output int lat, output logic [1:0] dd, output logic bb, output bit busy_ok);
    @(negedge clk);
    start2 = 1'b1; x2 = xa; y2 = ya;
    lat = -1; busy_ok = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) start2 = 1'b0;
      if (done2 === 1'b1) begin
        lat = i - 1;
        if (busy2 !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (busy2 !== 1'b1) busy_ok = 1'b0;
    end
    dd = d2; bb = borrow2;
    if (lat < 0) begin
      n_cmp++; n_err++;
      $display("FAIL op2_timeout x=%0d y=%0d: done never seen within 40 cycles", xa, ya);
    end
  endtask

  // One WIDTH=4 operation; also reports whether d stayed unchanged until done.
  task automatic op4(input logic [3:0] xa, input logic [3:0] ya,
                     output int lat, output logic [3:0] dd, output logic bb, output bit stable);
    logic [3:0] d0;
    @(negedge clk);
    start4 = 1'b1; x4 = xa; y4 = ya; d0 = d4;
    lat = -1; stable = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start4 = 1'b0;
        x4 = 4'($urandom);
        y4 = 4'($urandom);
      end
      if (done4 === 1'b1) begin
        lat = i - 1;
        break;
      end
      if (d4 !== d0) stable = 1'b0;
    end
    dd = d4; bb = borrow4;
    if (lat < 0) begin
      n_cmp++; n_err++;
      $display("FAIL op4_timeout x=%0d y=%0d: done never seen within 40 cycles", xa, ya);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start2 = 1'b0; x2 = '0; y2 = '0;
    start4 = 1'b0; x4 = '0; y4 = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy2, done2, d2, borrow2} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_w2 got busy=%b done=%b d=%0d borrow=%b want all 0", busy2, done2, d2, borrow2);
    end
    n_cmp++;
    if ({busy4, done4, d4, borrow4} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_w4 got busy=%b done=%b d=%0d borrow=%b want all 0", busy4, done4, d4, borrow4);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_exhaustive_w2();
    int lat; logic [1:0] dd; logic bb; bit bok;
    int exp_d; logic exp_b;
    for (int xi = 0; xi < 4; xi++) begin
      for (int yi = 0; yi < 4; yi++) begin
        op2(2'(xi), 2'(yi), lat, dd, bb, bok);
        exp_d = (xi - yi) & 3;
        exp_b = (xi < yi);
        n_cmp++;
        if (dd !== 2'(exp_d) || bb !== exp_b) begin
          n_err++;
          $display("FAIL w2_result x=%0d y=%0d got d=%0d b=%b want d=%0d b=%b", xi, yi, dd, bb, exp_d, exp_b);
        end
        n_cmp++;
        if (lat != 2 || !bok) begin
          n_err++;
          $display("FAIL w2_timing x=%0d y=%0d got latency=%0d busy_ok=%0d want latency=2 busy_ok=1", xi, yi, lat, bok);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_directed_w4();
    logic [3:0] xs [4] = '{4'd5, 4'd3, 4'd0, 4'd15};
    logic [3:0] ys [4] = '{4'd3, 4'd5, 4'd1, 4'd15};
    logic [3:0] ed [4] = '{4'd2, 4'd14, 4'd15, 4'd0};
    logic       eb [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int lat; logic [3:0] dd; logic bb; bit st;
    for (int k = 0; k < 4; k++) begin
      op4(xs[k], ys[k], lat, dd, bb, st);
      n_cmp++;
      if (dd !== ed[k] || bb !== eb[k] || lat != 4) begin
        n_err++;
        $display("FAIL w4_directed x=%0d y=%0d got d=%0d b=%b lat=%0d want d=%0d b=%b lat=4",
                 xs[k], ys[k], dd, bb, lat, ed[k], eb[k]);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int ndone; logic [3:0] dd; logic bb;
    ndone = 0; dd = '0; bb = 1'b1;
    @(negedge clk);
    start4 = 1'b1; x4 = 4'd9; y4 = 4'd4;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    start4 = 1'b1; x4 = 4'd1; y4 = 4'd7;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      start4 = 1'b0;
      if (done4 === 1'b1) begin
        ndone++; dd = d4; bb = borrow4;
      end
    end
    n_cmp++;
    if (ndone != 1) begin
      n_err++;
      $display("FAIL busy_start_pulses got %0d done pulses want 1", ndone);
    end
    n_cmp++;
    if (dd !== 4'd5 || bb !== 1'b0) begin
      n_err++;
      $display("FAIL busy_start_result got d=%0d b=%b want d=5 b=0", dd, bb);
    end
  endtask

  task automatic test_back_to_back();
    int t1, t2; bit bok;
    logic [3:0] da, db; logic ba, bbv;
    t1 = -1; t2 = -1; bok = 1'b1;
    da = '0; db = '0; ba = 1'b1; bbv = 1'b0;
    @(negedge clk);
    start4 = 1'b1; x4 = 4'd12; y4 = 4'd2;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (busy4 === done4) bok = 1'b0;
      if (done4 === 1'b1) begin
        if (t1 < 0) begin
          t1 = i; da = d4; ba = borrow4;
          x4 = 4'd2; y4 = 4'd12;
        end else begin
          t2 = i; db = d4; bbv = borrow4;
          start4 = 1'b0;
          break;
        end
      end
    end
    start4 = 1'b0;
    n_cmp++;
    if (t1 < 0 || t2 < 0 || (t2 - t1) != 5) begin
      n_err++;
      $display("FAIL b2b_spacing got first=%0d second=%0d want 5 cycles apart", t1, t2);
    end
    n_cmp++;
    if (da !== 4'd10 || ba !== 1'b0 || db !== 4'd6 || bbv !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_results got %0d/%b then %0d/%b want 10/0 then 6/1", da, ba, db, bbv);
    end
    n_cmp++;
    if (!bok) begin
      n_err++;
      $display("FAIL b2b_busy got busy equal to done in some cycle want busy low only on done cycles");
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    int ndone, lat; logic [3:0] dd; logic bb; bit st;
    ndone = 0;
    @(negedge clk);
    start4 = 1'b1; x4 = 4'd7; y4 = 4'd1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy4, done4, d4, borrow4} !== 7'b0) begin
      n_err++;
      $display("FAIL midop_reset got busy=%b done=%b d=%0d borrow=%b want all 0", busy4, done4, d4, borrow4);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done4 === 1'b1) ndone++;
    end
    n_cmp++;
    if (ndone != 0) begin
      n_err++;
      $display("FAIL midop_no_done got %0d done pulses want 0", ndone);
    end
    op4(4'd8, 4'd8, lat, dd, bb, st);
    n_cmp++;
    if (dd !== 4'd0 || bb !== 1'b0 || lat != 4) begin
      n_err++;
      $display("FAIL midop_restart got d=%0d b=%b lat=%0d want d=0 b=0 lat=4", dd, bb, lat);
    end
  endtask

  task automatic test_round_trip();
    int lat; logic [3:0] dd; logic bb; bit st;
    logic [3:0] xa, ya;
    for (int k = 0; k < 200; k++) begin
      xa = 4'($urandom);
      ya = 4'($urandom);
      op4(xa, ya, lat, dd, bb, st);
      n_cmp++;
      if (4'(ya + dd) !== xa || bb !== (xa < ya)) begin
        n_err++;
        $display("FAIL round_trip x=%0d y=%0d got d=%0d b=%b want y+d=x b=%b", xa, ya, dd, bb, (xa < ya));
      end
      n_cmp++;
      if (!st || lat != 4) begin
        n_err++;
        $display("FAIL round_trip_stable x=%0d y=%0d got stable=%0d lat=%0d want stable=1 lat=4", xa, ya, st, lat);
      end
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        n_cmp++;
        if (d4 !== dd) begin
          n_err++;
          $display("FAIL idle_hold got d=%0d want %0d", d4, dd);
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_exhaustive_w2();
    test_directed_w4();
    test_start_while_busy();
    test_back_to_back();
    test_reset_midop();
    test_round_trip();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
